data_bus_arbiter: RTL and testbench
===================================

Name: data_bus_arbiter

Overview:
- Shares the single external data-memory bus (bus_data/bus_addr/read/write) between two requesters: master 0 is the CPU data port and master 1 is the DMA/loader port.
- Runs round-robin arbitration and drives one bus transaction per grant.
- Owns the bus_data tristate and returns read data with a one-cycle ack.
- Sits between the requesters and every data_memory instance on the bus.

Parameters:
- ADDR_WIDTH, 20, bus address width.
- DATA_WIDTH, 16, bus data width.
- ADDR_LIMIT, 20'hFFFFF, highest legal address; a request above it is rejected with err and no bus cycle.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  1  master 0 request; held high until m0_ack or m0_err.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_WIDTH  request address.
- m0_wdata  in  DATA_WIDTH  write data.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  one-cycle error pulse (address > ADDR_LIMIT).
- m0_rdata  out  DATA_WIDTH  read data; valid while m0_ack=1 and held until the next master-0 read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same meanings and directions as the master-0 ports.
- bus_data  inout  DATA_WIDTH  shared data bus.
- bus_addr  out  ADDR_WIDTH  shared address bus.
- read  out  1  bus read strobe.
- write  out  1  bus write strobe.
- grant  out  2  one-hot owner of the current transaction; 0 when idle.
- busy  out  1  high while the state is ACCESS.

Behaviour:
- Reset values:
  - state IDLE; rr pointer favours m0.
  - bus_addr=0, read=0, write=0, bus_data=Z, grant=0, busy=0.
  - all ack/err=0; all rdata=0.
- States:
  - IDLE: evaluate eligible requests at each rising edge.
  - ACCESS: exactly one cycle.
- Eligibility: mX_req=1 and mX_ack=0 and mX_err=0 in the current cycle. This blocks re-issue while the requester is dropping req.
- IDLE, no eligible request: stay in IDLE.
- IDLE, one eligible request: serve it.
- IDLE, both eligible: serve the master the rr pointer favours; the pointer then flips to the other master.
  - The pointer updates only when a bus transaction is issued; err responses leave it unchanged.
- Serving a request with address > ADDR_LIMIT:
  - pulse mX_err=1 for one cycle on the next cycle.
  - no bus activity; stay in IDLE.
- Serving a legal request:
  - latch addr, wdata and op into bus registers; set grant; move to ACCESS.
- Timing of a legal transaction:
  - Cycle N (IDLE): request sampled at the rising edge that ends cycle N.
  - Cycle N+1 (ACCESS):
    - bus_addr = latched address; read = !we; write = we; busy=1.
    - bus_data driven with latched wdata only when write=1, otherwise Z.
    - memory read is asynchronous, so on a read the arbiter captures bus_data into mX_rdata at the rising edge ending cycle N+1.
    - memory write is synchronous and commits at that same edge.
  - Cycle N+2 (IDLE):
    - mX_ack=1; read=0, write=0, grant=0; bus_data=Z.
    - arbitration of the other master may issue in this same cycle, so back-to-back ACCESS is 1 cycle in every 2.
- Latency: request to ack is 2 cycles.
- Maximum throughput: one transaction per 2 cycles.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, …
- Strobe rules: read and write are never high together; neither is high outside ACCESS.
- Reset during ACCESS:
  - the edge-coincident memory write still commits, because the memory is not reset.
  - no ack is issued; all outputs take their reset values at that edge.
- Requests changing during ACCESS are ignored; the latched values are used.

Decomposition:
- Shared package data_bus_pkg:
  - ADDR_WIDTH/DATA_WIDTH defaults.
  - state encodings ST_IDLE=1'b0, ST_ACCESS=1'b1.
  - grant encodings GNT_NONE=2'b00, GNT_M0=2'b01, GNT_M1=2'b10.
- Sub-module rr_arbiter2:
  - combinational grant from (eligible[1:0], pointer), plus the registered pointer update on issue.
- The top level holds the FSM, address check, bus registers, tristate and response registers.

Test Plan:
- Single write: m0 write addr=20'h00010, wdata=16'hBEEF.
  - write=1 for exactly 1 cycle with bus_addr=20'h00010 and bus_data=16'hBEEF.
  - m0_ack pulses 2 cycles after req.
  - memory location 16 then holds 16'hBEEF.
- Single read: m1 reads addr 20'h00010 after the write above.
  - read=1 for 1 cycle; bus_data=Z from the arbiter side.
  - m1_ack with m1_rdata=16'hBEEF.
- Contention: m0 and m1 both request continuously for 6 transactions.
  - grant sequence 01,10,01,10,01,10.
  - busy toggles 1,0,1,0…; never 2 consecutive ACCESS cycles.
- Illegal address: ADDR_LIMIT=20'h000FF, m0 read addr=20'h00100.
  - m0_err pulse next cycle; read=0 and write=0 throughout; rr pointer unchanged, so m0 still wins a subsequent tie.
- Reset during ACCESS: assert reset in the ACCESS cycle of an m0 write to 20'h00020 with 16'h1234.
  - the location holds 16'h1234.
  - no m0_ack; next cycle all outputs at reset values and bus_data=Z.
- Req held through ack: m0 keeps req=1 one cycle after m0_ack.
  - no second transaction is issued in the ack cycle.
  - a new transaction issues only if req is still high in the following cycle.

Source files
------------

// File: rtl/data_bus_pkg.sv
// Shared types and encodings for the two-master data-memory bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package data_bus_pkg;

  localparam int DEF_ADDR_WIDTH = 20;
  localparam int DEF_DATA_WIDTH = 16;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/data_bus_arbiter_rr.sv
// Two-way round-robin picker: one-hot grant from eligible requests and a fairness pointer.
// Latency: grant is combinational; the pointer updates on the edge that issues a bus cycle.
// Backpressure: none; a master that loses simply stays eligible for the next arbitration.
module rr_arbiter2
  import data_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_elig,
  input  logic       i_issue,
  output logic [1:0] o_gnt
);

  // 0 favours master 0 on a tie, 1 favours master 1
  logic r_ptr;

  // pick a single winner; the pointer only matters when both are eligible
  always_comb begin
    o_gnt = GNT_NONE;
    case (i_elig)
      2'b01:   o_gnt = GNT_M0;
      2'b10:   o_gnt = GNT_M1;
      2'b11:   o_gnt = r_ptr ? GNT_M1 : GNT_M0;
      default: o_gnt = GNT_NONE;
    endcase
  end

  // after a real bus cycle, favour whichever master did not just get served
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
    end else if (i_issue) begin
      r_ptr <= o_gnt[0];
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the data-memory bus between the CPU (m0) and DMA (m1) ports, one transaction per grant.
// Latency: request to ack is 2 cycles; back-to-back transactions every 2 cycles.
// Backpressure: requesters hold req until ack/err; a losing or just-acked master waits in IDLE.
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 20'hFFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_ack,
  output logic                  m0_err,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_ack,
  output logic                  m1_err,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  read,
  output logic                  write,
  output logic [1:0]            grant,
  output logic                  busy
);

  state_t                r_state;
  logic [1:0]            r_grant;
  logic [ADDR_WIDTH-1:0] r_bus_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_read;
  logic                  r_write;
  logic                  r_m0_ack;
  logic                  r_m1_ack;
  logic                  r_m0_err;
  logic                  r_m1_err;
  logic [DATA_WIDTH-1:0] r_m0_rdata;
  logic [DATA_WIDTH-1:0] r_m1_rdata;

  logic [1:0]            w_elig;
  logic [1:0]            w_gnt;
  logic [ADDR_WIDTH-1:0] w_req_addr;
  logic [DATA_WIDTH-1:0] w_req_wdata;
  logic                  w_req_we;
  logic                  w_illegal;
  logic                  w_issue;

  // a master that is being acked or errored this cycle is still dropping req; ignore it
  assign w_elig[0] = (r_state == ST_IDLE) & m0_req & ~r_m0_ack & ~r_m0_err;
  assign w_elig[1] = (r_state == ST_IDLE) & m1_req & ~r_m1_ack & ~r_m1_err;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .i_elig  (w_elig),
    .i_issue (w_issue),
    .o_gnt   (w_gnt)
  );

  assign w_req_addr  = w_gnt[1] ? m1_addr  : m0_addr;
  assign w_req_wdata = w_gnt[1] ? m1_wdata : m0_wdata;
  assign w_req_we    = w_gnt[1] ? m1_we    : m0_we;
  assign w_illegal   = (w_req_addr > ADDR_LIMIT);
  // out-of-range requests are answered with err and must not advance fairness
  assign w_issue     = (w_gnt != GNT_NONE) & ~w_illegal;

  // FSM: IDLE arbitrates and latches the winner, ACCESS runs exactly one bus cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_grant    <= GNT_NONE;
      r_bus_addr <= '0;
      r_wdata    <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_m0_ack   <= 1'b0;
      r_m1_ack   <= 1'b0;
      r_m0_err   <= 1'b0;
      r_m1_err   <= 1'b0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      r_m0_ack <= 1'b0;
      r_m1_ack <= 1'b0;
      r_m0_err <= 1'b0;
      r_m1_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt != GNT_NONE) begin
            if (w_illegal) begin
              r_m0_err <= w_gnt[0];
              r_m1_err <= w_gnt[1];
            end else begin
              r_state    <= ST_ACCESS;
              r_grant    <= w_gnt;
              r_bus_addr <= w_req_addr;
              r_wdata    <= w_req_wdata;
              r_read     <= ~w_req_we;
              r_write    <= w_req_we;
            end
          end
        end
        ST_ACCESS: begin
          r_state  <= ST_IDLE;
          r_grant  <= GNT_NONE;
          r_read   <= 1'b0;
          r_write  <= 1'b0;
          r_m0_ack <= r_grant[0];
          r_m1_ack <= r_grant[1];
          // memory read is asynchronous, so the data is settled on the bus by this edge
          if (r_read) begin
            if (r_grant[0]) r_m0_rdata <= bus_data;
            if (r_grant[1]) r_m1_rdata <= bus_data;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus_data = r_write ? r_wdata : {DATA_WIDTH{1'bz}};
  assign bus_addr = r_bus_addr;
  assign read     = r_read;
  assign write    = r_write;
  assign grant    = r_grant;
  assign busy     = (r_state == ST_ACCESS);
  assign m0_ack   = r_m0_ack;
  assign m1_ack   = r_m1_ack;
  assign m0_err   = r_m0_err;
  assign m1_err   = r_m1_err;
  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: memory on the bus, transaction-level model, directed scenarios.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_data_bus_arbiter;

  localparam int AW = 20;
  localparam int DW = 16;
  localparam logic [AW-1:0] LIMIT = 20'h000FF;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  wire           m0_ack, m0_err, m1_ack, m1_err;
  wire  [DW-1:0] m0_rdata, m1_rdata;
  wire  [DW-1:0] bus_data;
  wire  [AW-1:0] bus_addr;
  wire           read, write, busy;
  wire  [1:0]    grant;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  logic [1:0] gseq [$];

  always #5 clk = ~clk;

  data_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .bus_data(bus_data), .bus_addr(bus_addr), .read(read), .write(write),
    .grant(grant), .busy(busy)
  );

  // data memory on the bus: asynchronous read, synchronous write, never reset
  logic [DW-1:0] mem [0:255];
  assign bus_data = read ? mem[8'(bus_addr)] : {DW{1'bz}};
  always @(posedge clk) if (write) mem[8'(bus_addr)] <= bus_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // transaction-level model: one outstanding bus cycle, fairness pointer, shadow memory
  logic [DW-1:0] smem [0:255];
  bit            e_busy, e_read, e_write, ptr;
  bit [1:0]      e_grant, e_ack, e_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [DW-1:0] e_rdata [0:1];
  int            cur_m;

  always @(posedge clk) begin : model
    bit [1:0] elig;
    int w;
    logic [AW-1:0] a;
    bit we;
    if (reset) begin
      if (e_write) smem[8'(e_addr)] = e_wdata;
      e_busy = 0; e_read = 0; e_write = 0; e_grant = 0; e_ack = 0; e_err = 0;
      e_addr = '0; ptr = 0; e_rdata[0] = '0; e_rdata[1] = '0;
    end else if (e_busy) begin
      if (e_write) smem[8'(e_addr)] = e_wdata;
      else e_rdata[cur_m] = smem[8'(e_addr)];
      e_ack = 2'b00; e_ack[cur_m] = 1'b1; e_err = 2'b00;
      e_busy = 0; e_read = 0; e_write = 0; e_grant = 0;
    end else begin
      elig[0] = m0_req && !e_ack[0] && !e_err[0];
      elig[1] = m1_req && !e_ack[1] && !e_err[1];
      e_ack = 2'b00; e_err = 2'b00;
      if (elig != 2'b00) begin
        if (elig == 2'b11) w = ptr ? 1 : 0;
        else w = elig[1] ? 1 : 0;
        a = (w == 1) ? m1_addr : m0_addr;
        if (a > LIMIT) begin
          e_err[w] = 1'b1;
        end else begin
          we      = (w == 1) ? m1_we : m0_we;
          cur_m   = w;
          e_busy  = 1;
          e_addr  = a;
          e_wdata = (w == 1) ? m1_wdata : m0_wdata;
          e_write = we;
          e_read  = !we;
          e_grant = (w == 1) ? 2'b10 : 2'b01;
          ptr     = (w == 0);
        end
      end
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("grant", grant, e_grant);
      chk("busy", busy, e_busy);
      chk("read", read, e_read);
      chk("write", write, e_write);
      chk("bus_addr", bus_addr, e_addr);
      chk("m0_ack", m0_ack, e_ack[0]);
      chk("m1_ack", m1_ack, e_ack[1]);
      chk("m0_err", m0_err, e_err[0]);
      chk("m1_err", m1_err, e_err[1]);
      chk("m0_rdata", m0_rdata, e_rdata[0]);
      chk("m1_rdata", m1_rdata, e_rdata[1]);
      chk("strobe_excl", read & write, 0);
      if (e_write) chk("bus_wdata", bus_data, e_wdata);
      if (e_read) chk("bus_rdata", bus_data, smem[8'(e_addr)]);
      if (busy) gseq.push_back(grant);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c0, c1;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      smem[i] = '0;
    end
    chk_en = 1'b1;
    @(negedge clk);
    // reset state
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobes", {read, write}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_resp", {m0_ack, m0_err, m1_ack, m1_err}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    reset = 1'b0;

    // single write from m0
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 20'h00010; m0_wdata = 16'hBEEF;
    @(negedge clk);
    chk("wr_strobe", write, 1);
    chk("wr_addr", bus_addr, 20'h00010);
    chk("wr_data", bus_data, 16'hBEEF);
    chk("wr_grant", grant, 2'b01);
    @(negedge clk);
    chk("wr_ack", m0_ack, 1);
    chk("wr_strobe_done", write, 0);
    chk("wr_mem", mem[16], 16'hBEEF);
    m0_req = 0;
    @(negedge clk);
    chk("wr_ack_pulse", m0_ack, 0);

    // single read from m1
    m1_req = 1; m1_we = 0; m1_addr = 20'h00010;
    @(negedge clk);
    chk("rd_strobe", {read, write}, 2'b10);
    chk("rd_bus", bus_data, 16'hBEEF);
    @(negedge clk);
    chk("rd_ack", m1_ack, 1);
    chk("rd_data", m1_rdata, 16'hBEEF);
    m1_req = 0;
    @(negedge clk);

    // contention: both masters request continuously for three transactions each
    gseq.delete();
    c0 = 0; c1 = 0;
    m0_req = 1; m0_we = 1; m0_addr = 20'h00030; m0_wdata = 16'h5A5A;
    m1_req = 1; m1_we = 0; m1_addr = 20'h00010;
    for (int k = 0; k < 40 && !(c0 == 3 && c1 == 3); k++) begin
      @(negedge clk);
      if (m0_ack) begin c0++; if (c0 == 3) m0_req = 0; end
      if (m1_ack) begin c1++; if (c1 == 3) m1_req = 0; end
    end
    chk("cont_count", c0 + c1, 6);
    chk("cont_len", gseq.size(), 6);
    for (int i = 0; i < 6 && i < gseq.size(); i++)
      chk("cont_grant", gseq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    chk("cont_mem", mem[8'h30], 16'h5A5A);

    // out-of-range address is refused without a bus cycle
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 20'h00100;
    @(negedge clk);
    chk("ill_err", m0_err, 1);
    chk("ill_strobes", {read, write, busy}, 0);
    m0_req = 0;
    @(negedge clk);
    chk("ill_err_pulse", m0_err, 0);
    // pointer untouched by the error: m0 still wins the tie
    m0_req = 1; m0_we = 0; m0_addr = 20'h00010;
    m1_req = 1; m1_we = 0; m1_addr = 20'h00030;
    @(negedge clk);
    chk("tie_after_err", grant, 2'b01);
    for (int k = 0; k < 20 && (m0_req || m1_req); k++) begin
      @(negedge clk);
      if (m0_ack) m0_req = 0;
      if (m1_ack) m1_req = 0;
    end
    chk("tie_done", {m0_req, m1_req}, 0);
    chk("tie_m1_rdata", m1_rdata, 16'h5A5A);

    // reset lands in the ACCESS cycle of a write
    @(negedge clk);
    m0_req = 1; m0_we = 1; m0_addr = 20'h00020; m0_wdata = 16'h1234;
    @(negedge clk);
    chk("rstacc_write", write, 1);
    reset = 1; m0_req = 0;
    @(negedge clk);
    chk("rstacc_mem", mem[8'h20], 16'h1234);
    chk("rstacc_noack", m0_ack, 0);
    chk("rstacc_outs", {grant, busy, read, write}, 0);
    chk("rstacc_addr", bus_addr, 0);
    chk("rstacc_rdata", m0_rdata, 0);
    reset = 0;

    // req held past ack: no reissue in the ack cycle, reissue only one cycle later
    @(negedge clk);
    m0_req = 1; m0_we = 0; m0_addr = 20'h00020;
    for (int k = 0; k < 10 && !m0_ack; k++) @(negedge clk);
    chk("hold_ack", m0_ack, 1);
    chk("hold_rdata", m0_rdata, 16'h1234);
    @(negedge clk);
    chk("hold_no_reissue", busy, 0);
    @(negedge clk);
    chk("hold_reissue", {busy, grant}, 3'b101);
    @(negedge clk);
    chk("hold_ack2", m0_ack, 1);
    m0_req = 0;
    @(negedge clk);
    chk("hold_idle", busy, 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
